// File: rtl/ctrl_ex_pipe.sv
// -----------------------------------------------------------------------------
// ctrl_ex_pipe
// -----------------------------------------------------------------------------
// Execute-stage control for a 16-bit Thumb-style pipeline.
//
// Decodes conditional (Bcc) and unconditional (B) branches from the EX
// instruction and evaluates the condition against the APSR flags. The IR and
// its valid bit are then carried through STAGES downstream registers (stage 0
// is MEM). After a taken branch the next FLUSH_CYCLES instructions that reach
// EX are wrong-path, so they are squashed into NOP bubbles. External flush
// clears the whole pipe, and stall freezes all state.
//
// Optional feature (compile-time macro CTRL_EX_BRANCH_CNT_EN):
//   defined   - o_branch_cnt counts RUN->FLUSH transitions, saturating,
//               cleared only by rst.
//   undefined - o_branch_cnt is tied to 0 and no counter register exists.
//
// Parameters
//   IR_W          instruction width (condition decode uses bits [15:8])
//   STAGES        number of downstream pipeline registers (>=1)
//   FLUSH_CYCLES  wrong-path slots squashed after a taken branch (1..15)
//   NOP_WORD      IR value used for squashed slots and after reset
//   CNT_W         branch counter width
//
// Ports
//   clk           in   clock, rising edge
//   rst           in   synchronous reset, active-high
//   i_ir          in   instruction currently in EX
//   i_ir_valid    in   i_ir is a real instruction
//   i_apsr        in   flags {N,Z,C,V}, bit 3 = N
//   i_stall       in   hold all state this cycle
//   i_flush       in   external flush, overrides stall
//   o_branch_met  out  EX instruction is a taken branch (combinational)
//   o_ir_mem      out  IR in stage 0
//   o_valid_mem   out  valid of stage 0
//   o_ir_pipe     out  all stage IRs, stage k at [k*IR_W +: IR_W]
//   o_valid_pipe  out  valid bit per stage
//   o_flushing    out  FSM is squashing wrong-path instructions
//   o_branch_cnt  out  taken-branch count
// -----------------------------------------------------------------------------
module ctrl_ex_pipe #(
    parameter int              IR_W         = 16,
    parameter int              STAGES       = 2,
    parameter int              FLUSH_CYCLES = 2,
    parameter logic [IR_W-1:0] NOP_WORD     = 16'hBF00,
    parameter int              CNT_W        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IR_W-1:0]          i_ir,
    input  logic                     i_ir_valid,
    input  logic [3:0]               i_apsr,
    input  logic                     i_stall,
    input  logic                     i_flush,
    output logic                     o_branch_met,
    output logic [IR_W-1:0]          o_ir_mem,
    output logic                     o_valid_mem,
    output logic [STAGES*IR_W-1:0]   o_ir_pipe,
    output logic [STAGES-1:0]        o_valid_pipe,
    output logic                     o_flushing,
    output logic [CNT_W-1:0]         o_branch_cnt
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // Condition codes in Thumb encoding order.
    typedef enum logic [3:0] {
        CC_EQ = 4'd0,  CC_NE = 4'd1,  CC_CS = 4'd2,  CC_CC = 4'd3,
        CC_MI = 4'd4,  CC_PL = 4'd5,  CC_VS = 4'd6,  CC_VC = 4'd7,
        CC_HI = 4'd8,  CC_LS = 4'd9,  CC_GE = 4'd10, CC_LT = 4'd11,
        CC_GT = 4'd12, CC_LE = 4'd13, CC_UDF = 4'd14, CC_SVC = 4'd15
    } cond_e;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    // -------------------------------------------------------------------------
    // Branch decode and condition evaluation
    // -------------------------------------------------------------------------
    logic  flag_n, flag_z, flag_c, flag_v;
    cond_e cond;
    logic  is_bcond;
    logic  is_b;
    logic  cond_true;
    logic  run;
    logic  branch_met;
    logic  take_branch;

    assign {flag_n, flag_z, flag_c, flag_v} = i_apsr;
    assign cond     = cond_e'(i_ir[11:8]);
    // Encodings 14 and 15 under the 1101 prefix are UDF/SVC, not branches.
    assign is_bcond = (i_ir[15:12] == 4'b1101) && (cond != CC_UDF) && (cond != CC_SVC);
    assign is_b     = (i_ir[15:11] == 5'b11100);

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            CC_EQ:   cond_true = flag_z;
            CC_NE:   cond_true = !flag_z;
            CC_CS:   cond_true = flag_c;
            CC_CC:   cond_true = !flag_c;
            CC_MI:   cond_true = flag_n;
            CC_PL:   cond_true = !flag_n;
            CC_VS:   cond_true = flag_v;
            CC_VC:   cond_true = !flag_v;
            CC_HI:   cond_true = flag_c && !flag_z;
            CC_LS:   cond_true = !flag_c || flag_z;
            CC_GE:   cond_true = (flag_n == flag_v);
            CC_LT:   cond_true = (flag_n != flag_v);
            CC_GT:   cond_true = !flag_z && (flag_n == flag_v);
            CC_LE:   cond_true = flag_z || (flag_n != flag_v);
            default: cond_true = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Squash FSM
    // -------------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [3:0] flush_cnt_q, flush_cnt_d;

    assign run = (state_q == ST_RUN);

    // A wrong-path branch (seen while in FLUSH) is never reported as met.
    assign branch_met  = (is_b || (is_bcond && cond_true)) && i_ir_valid && run && !i_flush;
    // Only an unstalled taken branch actually redirects the pipe.
    assign take_branch = branch_met && !i_stall;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (i_flush) begin
            state_d     = ST_RUN;
            flush_cnt_d = 4'd0;
        end else if (!i_stall) begin
            case (state_q)
                ST_RUN: begin
                    if (take_branch) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end
                end
                ST_FLUSH: begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                    // This cycle's squash was the last one.
                    if (flush_cnt_q == 4'd1) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d     = ST_RUN;
                    flush_cnt_d = 4'd0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; combinational blocks use blocking ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Downstream IR/valid registers
    // -------------------------------------------------------------------------
    logic [IR_W-1:0] ir_q    [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [IR_W-1:0] ir0_d;
    logic            valid0_d;

    // In FLUSH the EX slot is wrong-path and becomes a bubble.
    assign ir0_d    = run ? i_ir : NOP_WORD;
    assign valid0_d = i_ir_valid && run;

    // NOTE: the stage array is small and must show NOP bubbles after reset,
    // so it is reset like ordinary flops rather than left uninitialised.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            for (int k = 0; k < STAGES; k++) begin
                ir_q[k] <= NOP_WORD;
            end
            valid_q <= '0;
        end else if (!i_stall) begin
            ir_q[0]    <= ir0_d;
            valid_q[0] <= valid0_d;
            for (int k = 1; k < STAGES; k++) begin
                ir_q[k]    <= ir_q[k-1];
                valid_q[k] <= valid_q[k-1];
            end
        end
    end

    always_comb begin
        o_ir_pipe = '0;
        for (int k = 0; k < STAGES; k++) begin
            o_ir_pipe[k*IR_W +: IR_W] = ir_q[k];
        end
    end

    assign o_valid_pipe = valid_q;
    assign o_ir_mem     = ir_q[0];
    assign o_valid_mem  = valid_q[0];
    assign o_branch_met = branch_met;
    assign o_flushing   = (state_q == ST_FLUSH);

    // -------------------------------------------------------------------------
    // Optional taken-branch counter
    // -------------------------------------------------------------------------
`ifdef CTRL_EX_BRANCH_CNT_EN
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;

    always_comb begin
        branch_cnt_d = branch_cnt_q;
        // Increment on RUN->FLUSH only; external flush does not clear it.
        if (take_branch && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q <= '0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
        end
    end

    assign o_branch_cnt = branch_cnt_q;
`else
    assign o_branch_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_ex_pipe.sv
// -----------------------------------------------------------------------------
// tb_ctrl_ex_pipe
// Directed self-checking bench for ctrl_ex_pipe (STAGES=2, FLUSH_CYCLES=2,
// CNT_W=2). Inputs change 1 time unit after the rising edge; outputs are
// sampled there too, so registered values reflect the preceding edge.
// -----------------------------------------------------------------------------
module tb_ctrl_ex_pipe;

    localparam int IR_W  = 16;
    localparam int STG   = 2;
    localparam int CNT_W = 2;

`ifdef CTRL_EX_BRANCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic                   clk;
    logic                   rst;
    logic [IR_W-1:0]        i_ir;
    logic                   i_ir_valid;
    logic [3:0]             i_apsr;
    logic                   i_stall;
    logic                   i_flush;
    logic                   o_branch_met;
    logic [IR_W-1:0]        o_ir_mem;
    logic                   o_valid_mem;
    logic [STG*IR_W-1:0]    o_ir_pipe;
    logic [STG-1:0]         o_valid_pipe;
    logic                   o_flushing;
    logic [CNT_W-1:0]       o_branch_cnt;

    int n_checks = 0;
    int n_errors = 0;

    ctrl_ex_pipe #(
        .IR_W        (IR_W),
        .STAGES      (STG),
        .FLUSH_CYCLES(2),
        .NOP_WORD    (16'hBF00),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_ir        (i_ir),
        .i_ir_valid  (i_ir_valid),
        .i_apsr      (i_apsr),
        .i_stall     (i_stall),
        .i_flush     (i_flush),
        .o_branch_met(o_branch_met),
        .o_ir_mem    (o_ir_mem),
        .o_valid_mem (o_valid_mem),
        .o_ir_pipe   (o_ir_pipe),
        .o_valid_pipe(o_valid_pipe),
        .o_flushing  (o_flushing),
        .o_branch_cnt(o_branch_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] ir, input logic v, input logic [3:0] apsr,
                         input logic stall, input logic flush);
        i_ir       = ir;
        i_ir_valid = v;
        i_apsr     = apsr;
        i_stall    = stall;
        i_flush    = flush;
        #1;
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
        int sat;
        sat = (n > 3) ? 3 : n;
        return CNT_EN ? 32'(sat) : 32'd0;
    endfunction

    initial begin
        rst = 1'b1;
        drive(16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_valid", 32'(o_valid_pipe), 32'h0);
        check("rst_ir",    32'(o_ir_pipe),    32'hBF00BF00);
        check("rst_flush", 32'(o_flushing),   32'h0);
        check("rst_cnt",   32'(o_branch_cnt), 32'h0);

        // Straight-line ALU instructions
        drive(16'h1840, 1'b1, 4'b0000, 1'b0, 1'b0);
        check("alu_met", 32'(o_branch_met), 32'h0);
        tick();
        check("alu1_mem",  32'(o_ir_mem),    32'h1840);
        check("alu1_vmem", 32'(o_valid_mem), 32'h1);
        drive(16'h1C0A, 1'b1, 4'b0000, 1'b0, 1'b0);
        tick();
        check("alu2_pipe", 32'(o_ir_pipe), 32'h18401C0A);
        drive(16'h4008, 1'b1, 4'b0000, 1'b0, 1'b0);
        tick();
        check("alu3_pipe",  32'(o_ir_pipe),    32'h1C0A4008);
        check("alu3_valid", 32'(o_valid_pipe), 32'h3);

        // Taken BEQ, two squashed slots, third passes
        drive(16'hD005, 1'b1, 4'b0100, 1'b0, 1'b0);
        check("beq_met", 32'(o_branch_met), 32'h1);
        tick();
        check("beq_mem",   32'(o_ir_mem),    32'hD005);
        check("beq_vmem",  32'(o_valid_mem), 32'h1);
        check("beq_flush", 32'(o_flushing),  32'h1);
        drive(16'hD005, 1'b1, 4'b0100, 1'b0, 1'b0);
        check("wrongpath_met", 32'(o_branch_met), 32'h0);
        tick();
        check("sq1_mem",   32'(o_ir_mem),     32'hBF00);
        check("sq1_valid", 32'(o_valid_pipe), 32'h2);
        check("sq1_flush", 32'(o_flushing),   32'h1);
        drive(16'h2222, 1'b1, 4'b0000, 1'b0, 1'b0);
        tick();
        check("sq2_pipe",  32'(o_ir_pipe),    32'hBF00BF00);
        check("sq2_valid", 32'(o_valid_pipe), 32'h0);
        check("sq2_flush", 32'(o_flushing),   32'h0);
        drive(16'h3333, 1'b1, 4'b0000, 1'b0, 1'b0);
        tick();
        check("post_mem",  32'(o_ir_mem),    32'h3333);
        check("post_vmem", 32'(o_valid_mem), 32'h1);
        check("cnt1",      32'(o_branch_cnt), exp_cnt(1));

        // Not-taken and never-taken encodings
        drive(16'hD005, 1'b1, 4'b0000, 1'b0, 1'b0);
        check("beq_nt_met", 32'(o_branch_met), 32'h0);
        drive(16'hDE00, 1'b1, 4'b1111, 1'b0, 1'b0);
        check("udf_met", 32'(o_branch_met), 32'h0);
        drive(16'hDF00, 1'b1, 4'b0000, 1'b0, 1'b0);
        check("svc_met", 32'(o_branch_met), 32'h0);
        drive(16'hE004, 1'b0, 4'b0000, 1'b0, 1'b0);
        check("b_invalid_met", 32'(o_branch_met), 32'h0);
        drive(16'hDC02, 1'b1, 4'b1101, 1'b0, 1'b0);
        check("bgt_z_met", 32'(o_branch_met), 32'h0);
        drive(16'hD005, 1'b1, 4'b0000, 1'b0, 1'b0);
        tick();
        check("beq_nt_mem",   32'(o_ir_mem),   32'hD005);
        check("beq_nt_flush", 32'(o_flushing), 32'h0);

        // Taken BGT with N=V=1, Z=0
        drive(16'hDC02, 1'b1, 4'b1001, 1'b0, 1'b0);
        check("bgt_met", 32'(o_branch_met), 32'h1);
        tick();
        check("bgt_flush", 32'(o_flushing), 32'h1);
        drive(16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        tick();
        tick();
        check("bgt_done", 32'(o_flushing),   32'h0);
        check("cnt2",     32'(o_branch_cnt), exp_cnt(2));

        // External flush beats a simultaneous taken branch
        drive(16'hE004, 1'b1, 4'b0000, 1'b0, 1'b1);
        check("flush_b_met", 32'(o_branch_met), 32'h0);
        tick();
        check("flush_b_fsm",   32'(o_flushing),   32'h0);
        check("flush_b_valid", 32'(o_valid_pipe), 32'h0);
        check("flush_b_cnt",   32'(o_branch_cnt), exp_cnt(2));

        // Taken B held by stall for 3 cycles
        drive(16'h4444, 1'b1, 4'b0000, 1'b0, 1'b0);
        tick();
        drive(16'hE004, 1'b1, 4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("stall_met", 32'(o_branch_met), 32'h1);
            tick();
            check("stall_mem",   32'(o_ir_mem),   32'h4444);
            check("stall_flush", 32'(o_flushing), 32'h0);
        end
        drive(16'hE004, 1'b1, 4'b0000, 1'b0, 1'b0);
        check("unstall_met", 32'(o_branch_met), 32'h1);
        tick();
        check("unstall_mem",   32'(o_ir_mem),    32'hE004);
        check("unstall_pipe",  32'(o_ir_pipe),   32'h4444E004);
        check("unstall_flush", 32'(o_flushing),  32'h1);

        // Stall during FLUSH holds the squash counter
        drive(16'h6666, 1'b1, 4'b0000, 1'b1, 1'b0);
        tick();
        tick();
        check("fstall_flush", 32'(o_flushing), 32'h1);
        check("fstall_mem",   32'(o_ir_mem),   32'hE004);

        // External flush with stall during FLUSH
        drive(16'h5555, 1'b1, 4'b0000, 1'b1, 1'b1);
        tick();
        check("xflush_valid", 32'(o_valid_pipe), 32'h0);
        check("xflush_ir",    32'(o_ir_pipe),    32'hBF00BF00);
        check("xflush_fsm",   32'(o_flushing),   32'h0);
        check("cnt3",         32'(o_branch_cnt), exp_cnt(3));

        // Two more taken branches: counter saturates
        drive(16'hE004, 1'b1, 4'b0000, 1'b0, 1'b0);
        tick();
        drive(16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        tick();
        tick();
        drive(16'hD005, 1'b1, 4'b0100, 1'b0, 1'b0);
        tick();
        drive(16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        tick();
        tick();
        check("cnt_sat", 32'(o_branch_cnt), exp_cnt(5));

        // Reset in the middle of a flush, with stall asserted
        drive(16'hE004, 1'b1, 4'b0000, 1'b0, 1'b0);
        tick();
        check("pre_rst_flush", 32'(o_flushing), 32'h1);
        drive(16'h7777, 1'b1, 4'b0000, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_flush", 32'(o_flushing),   32'h0);
        check("mid_rst_valid", 32'(o_valid_pipe), 32'h0);
        check("mid_rst_ir",    32'(o_ir_pipe),    32'hBF00BF00);
        check("mid_rst_cnt",   32'(o_branch_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
